flags_stack_register: RTL and testbench
=======================================

# flags_stack_register

Parametrised NZCV status register for the ARM calculator datapath, successor to the single 32-bit enable-gated flags register. Derives N/Z from the ALU result, takes C/V from the ALU, applies a per-flag update mask, and provides a direct-write path. It also holds a DEPTH-entry LIFO for saving and restoring flags, and evaluates ARM condition codes against the current flags for conditional execution.

## Interface
- DATA_W, 32, ALU result width (≥ 2)
- DEPTH, 4, save-stack entries (≥ 1); CNT_W = $clog2(DEPTH+1)
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- upd_en  in  1  apply ALU-derived flags under upd_mask
- upd_mask  in  4  per-flag update enable, bit3..0 = N,Z,C,V
- alu_res  in  DATA_W  ALU result
- alu_c, alu_v  in  1 each  ALU carry / overflow
- wr_en  in  1  direct write of all four flags
- wr_data  in  4  value for direct write (N,Z,C,V)
- push  in  1  save current flags onto stack
- pop  in  1  restore flags from stack top
- err_clr  in  1  clear sticky err
- cond  in  4  ARM condition field
- flags  out  4  registered N,Z,C,V
- cond_pass  out  1  cond evaluated against flags
- depth_cnt  out  CNT_W  entries held
- full, empty  out  1 each  stack status
- err  out  1  sticky overflow/underflow

## Operation
- Derived values: dN = alu_res[DATA_W-1]; dZ = (alu_res == 0); dC = alu_c; dV = alu_v.
- Next-flags priority (highest first):
  - valid pop → flags <= stack top
  - wr_en → flags <= wr_data
  - upd_en → each bit i with upd_mask[i]=1 takes its derived value; others hold
  - otherwise hold
- Push stores flags as registered before the edge (pre-update value), never next-flags.
- Push and pop in the same cycle with depth_cnt ≥ 1 is a swap: flags <= top and top <= old flags; depth_cnt unchanged.
- Push+pop on empty: pop error; push proceeds, storing old flags; depth_cnt = 1.
- Push when full (no pop): entry dropped, err <= 1, depth_cnt held; flag update still applies.
- Pop when empty: ignored, err <= 1; wr_en/upd_en still apply.
- err is sticky. err_clr clears it. If a new error occurs in the same cycle as err_clr, the set wins.
- cond_pass is combinational from flags and cond:
  - EQ 0000 Z; NE 0001 !Z
  - CS 0010 C; CC 0011 !C
  - MI 0100 N; PL 0101 !N
  - VS 0110 V; VC 0111 !V
  - HI 1000 C&!Z; LS 1001 !C|Z
  - GE 1010 N==V; LT 1011 N!=V
  - GT 1100 !Z&(N==V); LE 1101 Z|(N!=V)
  - AL 1110 1; NV 1111 0

## Timing
- Reset (asynchronous, immediate):
  - flags = 0000, depth_cnt = 0, empty = 1, full = 0, err = 0
  - stack contents are don't-care
  - cond_pass follows cond against 0000 (e.g. AL = 1, EQ = 0)
- Flag, stack and err updates take effect at the rising clk edge: 1-cycle latency from inputs to flags.
- cond_pass has zero latency from cond and reflects flags as of the last edge. It never sees same-cycle updates (no bypass).
- full = (depth_cnt == DEPTH) and empty = (depth_cnt == 0), both derived from the registered count, glitch-free.
- Reset asserted mid-operation discards the stack; the first edge after rst_n rises behaves as from a fresh reset.

## Structure
- Shared package flags_pkg:
  - flag bit indices FLAG_N=3, FLAG_Z=2, FLAG_C=1, FLAG_V=0
  - 4-bit condition code constants COND_EQ … COND_NV
  - function cond_eval(cond, flags)
- Sub-module flags_save_stack: DEPTH×4 LIFO with push/pop/swap, depth_cnt/full/empty, and error pulses. Top level owns flag priority, err, and the cond_pass instance of cond_eval.

## Test plan
- Reset, then upd_en=1, mask=1111, alu_res=0, c=1, v=0 → flags=0110; cond=EQ → pass=1, cond=HI → pass=0.
- flags=0110, upd_en=1, mask=0001, alu_res=0x8000_0000, v=1 → flags=0111 (N, Z, C held).
- push flags=0111, then wr_en wr_data=1000, then pop → flags=0111, depth_cnt 1→0, empty=1.
- DEPTH=4: five pushes → depth_cnt=4, full=1, err=1 after the 5th; err_clr → err=0.
- Pop on empty with wr_en=1 wr_data=1001 → flags=1001, err=1, depth_cnt=0.
- Stack top=0011, flags=1100, push+pop together → flags=0011, top=1100, depth_cnt unchanged; rst_n pulse mid-sequence → flags=0000, empty=1.

Source files
------------

// File: rtl/flags_pkg.sv
// ----------------------------------------------------------------------------
// flags_pkg
// Shared definitions for the NZCV flags block:
//   - bit positions of N, Z, C and V inside the 4-bit flags word
//   - ARM condition-field encodings COND_EQ .. COND_NV
//   - cond_eval(): evaluates an ARM condition field against a flags word
// ----------------------------------------------------------------------------
package flags_pkg;

   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam logic [3:0] COND_EQ = 4'b0000;
   localparam logic [3:0] COND_NE = 4'b0001;
   localparam logic [3:0] COND_CS = 4'b0010;
   localparam logic [3:0] COND_CC = 4'b0011;
   localparam logic [3:0] COND_MI = 4'b0100;
   localparam logic [3:0] COND_PL = 4'b0101;
   localparam logic [3:0] COND_VS = 4'b0110;
   localparam logic [3:0] COND_VC = 4'b0111;
   localparam logic [3:0] COND_HI = 4'b1000;
   localparam logic [3:0] COND_LS = 4'b1001;
   localparam logic [3:0] COND_GE = 4'b1010;
   localparam logic [3:0] COND_LT = 4'b1011;
   localparam logic [3:0] COND_GT = 4'b1100;
   localparam logic [3:0] COND_LE = 4'b1101;
   localparam logic [3:0] COND_AL = 4'b1110;
   localparam logic [3:0] COND_NV = 4'b1111;

   function automatic logic cond_eval(input logic [3:0] cond, input logic [3:0] flags);
      logic n, z, c, v;
      n = flags[FLAG_N];
      z = flags[FLAG_Z];
      c = flags[FLAG_C];
      v = flags[FLAG_V];
      case (cond)
         COND_EQ: cond_eval = z;
         COND_NE: cond_eval = !z;
         COND_CS: cond_eval = c;
         COND_CC: cond_eval = !c;
         COND_MI: cond_eval = n;
         COND_PL: cond_eval = !n;
         COND_VS: cond_eval = v;
         COND_VC: cond_eval = !v;
         COND_HI: cond_eval = c & !z;
         COND_LS: cond_eval = !c | z;
         COND_GE: cond_eval = (n == v);
         COND_LT: cond_eval = (n != v);
         COND_GT: cond_eval = !z & (n == v);
         COND_LE: cond_eval = z | (n != v);
         COND_AL: cond_eval = 1'b1;
         default: cond_eval = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/flags_save_stack.sv
// ----------------------------------------------------------------------------
// flags_save_stack
// DEPTH-entry LIFO of 4-bit flag words.
//   clk, rst_n        : clock, asynchronous active-low reset (clears count only)
//   push, pop         : save din / discard top; both together with a non-empty
//                       stack swap din into the top slot
//   din               : word to save (the caller's current flags)
//   top               : current top entry (meaningless when empty)
//   depth_cnt         : number of entries held
//   full, empty       : decoded from the registered count
//   push_err, pop_err : single-cycle pulses for push-when-full / pop-when-empty
// ----------------------------------------------------------------------------
module flags_save_stack
   import flags_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         push,
   input  logic                         pop,
   input  logic [3:0]                   din,
   output logic [3:0]                   top,
   output logic [$clog2(DEPTH+1)-1:0]   depth_cnt,
   output logic                         full,
   output logic                         empty,
   output logic                         push_err,
   output logic                         pop_err
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [3:0]       mem_q [DEPTH];
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [IDX_W-1:0] top_idx, wr_idx;
   logic             mem_we;

   assign full      = (cnt_q == CNT_W'(DEPTH));
   assign empty     = (cnt_q == '0);
   assign depth_cnt = cnt_q;
   assign top_idx   = IDX_W'(cnt_q - CNT_W'(1));
   assign top       = mem_q[top_idx];

   always_comb begin
      cnt_d    = cnt_q;
      mem_we   = 1'b0;
      wr_idx   = top_idx;
      push_err = 1'b0;
      pop_err  = pop && empty;
      if (push && pop && !empty) begin
         // Swap: overwrite the top in place, count unchanged.
         mem_we = 1'b1;
         wr_idx = top_idx;
      end else begin
         if (pop && !empty) begin
            cnt_d = cnt_q - CNT_W'(1);
         end
         // Reached only when no valid pop is happening, so a push on an empty
         // stack with a (failed) pop still stores its entry.
         if (push) begin
            if (full) begin
               push_err = 1'b1;
            end else begin
               mem_we = 1'b1;
               wr_idx = IDX_W'(cnt_q);
               cnt_d  = cnt_q + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Stack contents need no reset: entries are only read below depth_cnt.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_idx] <= din;
      end
   end

endmodule

// File: rtl/flags_stack_register.sv
// ----------------------------------------------------------------------------
// flags_stack_register
// NZCV status register with masked ALU update, direct write, a save/restore
// LIFO and ARM condition evaluation.
//   clk, rst_n            : clock, asynchronous active-low reset
//   upd_en, upd_mask      : load ALU-derived flags for bits set in upd_mask
//   alu_res, alu_c, alu_v : ALU result (gives N, Z), carry and overflow
//   wr_en, wr_data        : direct write of all four flags
//   push, pop             : save current flags / restore from stack top
//   err_clr               : clear the sticky err bit
//   cond                  : ARM condition field
//   flags                 : registered N,Z,C,V
//   cond_pass             : cond evaluated against registered flags (no bypass)
//   depth_cnt, full, empty: stack occupancy
//   err                   : sticky push-overflow / pop-underflow indicator
// ----------------------------------------------------------------------------
module flags_stack_register
   import flags_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 4
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         upd_en,
   input  logic [3:0]                   upd_mask,
   input  logic [DATA_W-1:0]            alu_res,
   input  logic                         alu_c,
   input  logic                         alu_v,
   input  logic                         wr_en,
   input  logic [3:0]                   wr_data,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         err_clr,
   input  logic [3:0]                   cond,
   output logic [3:0]                   flags,
   output logic                         cond_pass,
   output logic [$clog2(DEPTH+1)-1:0]   depth_cnt,
   output logic                         full,
   output logic                         empty,
   output logic                         err
);

   logic [3:0] flags_q, flags_d;
   logic [3:0] derived;
   logic [3:0] stk_top;
   logic       err_q, err_d;
   logic       stk_empty;
   logic       push_err, pop_err;

   always_comb begin
      derived         = '0;
      derived[FLAG_N] = alu_res[DATA_W-1];
      derived[FLAG_Z] = (alu_res == '0);
      derived[FLAG_C] = alu_c;
      derived[FLAG_V] = alu_v;
   end

   // The stack always saves the pre-edge flags, so swap and push see old value.
   flags_save_stack #(
      .DEPTH (DEPTH)
   ) u_stack (
      .clk       (clk),
      .rst_n     (rst_n),
      .push      (push),
      .pop       (pop),
      .din       (flags_q),
      .top       (stk_top),
      .depth_cnt (depth_cnt),
      .full      (full),
      .empty     (stk_empty),
      .push_err  (push_err),
      .pop_err   (pop_err)
   );

   always_comb begin
      flags_d = flags_q;
      if (pop && !stk_empty) begin
         flags_d = stk_top;
      end else if (wr_en) begin
         flags_d = wr_data;
      end else if (upd_en) begin
         flags_d = (flags_q & ~upd_mask) | (derived & upd_mask);
      end
   end

   // A new error outranks a simultaneous clear.
   assign err_d = (err_q & ~err_clr) | push_err | pop_err;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         flags_q <= '0;
         err_q   <= 1'b0;
      end else begin
         flags_q <= flags_d;
         err_q   <= err_d;
      end
   end

   assign flags     = flags_q;
   assign err       = err_q;
   assign empty     = stk_empty;
   assign cond_pass = cond_eval(cond, flags_q);

endmodule

// File: tb/tb_flags_stack_register.sv
module tb_flags_stack_register;

   localparam int DATA_W = 32;
   localparam int DEPTH  = 4;
   localparam int CNT_W  = $clog2(DEPTH+1);

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              upd_en = 1'b0;
   logic [3:0]        upd_mask = '0;
   logic [DATA_W-1:0] alu_res = '0;
   logic              alu_c = 1'b0;
   logic              alu_v = 1'b0;
   logic              wr_en = 1'b0;
   logic [3:0]        wr_data = '0;
   logic              push = 1'b0;
   logic              pop = 1'b0;
   logic              err_clr = 1'b0;
   logic [3:0]        cond = '0;
   logic [3:0]        flags;
   logic              cond_pass;
   logic [CNT_W-1:0]  depth_cnt;
   logic              full;
   logic              empty;
   logic              err;

   flags_stack_register #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .upd_en(upd_en), .upd_mask(upd_mask),
      .alu_res(alu_res), .alu_c(alu_c), .alu_v(alu_v), .wr_en(wr_en),
      .wr_data(wr_data), .push(push), .pop(pop), .err_clr(err_clr),
      .cond(cond), .flags(flags), .cond_pass(cond_pass),
      .depth_cnt(depth_cnt), .full(full), .empty(empty), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [3:0] flags;
      int         cnt;
      logic       full;
      logic       empty;
      logic       err;
      logic       cp;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp = 0;
   int   n_fail = 0;

   // Reference model state
   logic [3:0] m_flags;
   logic [3:0] m_stack[$];
   logic       m_err;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
      end
   endtask

   // Predicate chosen by cond[3:1], inverted by cond[0].
   function automatic logic m_cond(input logic [3:0] cc, input logic [3:0] f);
      logic n, z, c, v, base;
      n = f[3]; z = f[2]; c = f[1]; v = f[0];
      case (cc[3:1])
         3'd0: base = z;
         3'd1: base = c;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = c && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      return cc[0] ? !base : base;
   endfunction

   // Monitor: every rising edge with a pending expectation is compared.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk("flags",     32'(flags),     32'(e.flags));
         chk("depth_cnt", 32'(depth_cnt), 32'(e.cnt));
         chk("full",      32'(full),      32'(e.full));
         chk("empty",     32'(empty),     32'(e.empty));
         chk("err",       32'(err),       32'(e.err));
         chk("cond_pass", 32'(cond_pass), 32'(e.cp));
      end
   end

   task automatic step(input logic u, input logic [3:0] msk, input logic [31:0] res,
                       input logic c, input logic v, input logic we, input logic [3:0] wd,
                       input logic ps, input logic pp, input logic ec, input logic [3:0] cc);
      logic [3:0] old, nxt, d;
      logic       newerr, did_pop;
      exp_t       e;
      @(negedge clk);
      upd_en = u; upd_mask = msk; alu_res = res; alu_c = c; alu_v = v;
      wr_en = we; wr_data = wd; push = ps; pop = pp; err_clr = ec; cond = cc;

      old = m_flags; nxt = old; newerr = 1'b0; did_pop = 1'b0;
      if (pp && ps && m_stack.size() > 0) begin
         nxt = m_stack[m_stack.size()-1];
         m_stack[m_stack.size()-1] = old;
         did_pop = 1'b1;
      end else begin
         if (pp) begin
            if (m_stack.size() > 0) begin
               nxt = m_stack.pop_back();
               did_pop = 1'b1;
            end else begin
               newerr = 1'b1;
            end
         end
         if (ps) begin
            if (m_stack.size() < DEPTH) m_stack.push_back(old);
            else newerr = 1'b1;
         end
      end
      if (!did_pop) begin
         if (we) nxt = wd;
         else if (u) begin
            d = {res[31], res == 32'd0, c, v};
            for (int i = 0; i < 4; i++) if (msk[i]) nxt[i] = d[i];
         end
      end
      if (ec) m_err = 1'b0;
      if (newerr) m_err = 1'b1;
      m_flags = nxt;

      #1;
      chk("cond_pass_pre", 32'(cond_pass), 32'(m_cond(cc, old)));
      e.flags = m_flags;
      e.cnt   = m_stack.size();
      e.full  = (m_stack.size() == DEPTH);
      e.empty = (m_stack.size() == 0);
      e.err   = m_err;
      e.cp    = m_cond(cc, m_flags);
      exp_q.push_back(e);
   endtask

   task automatic idle(input logic [3:0] cc);
      step(0, 4'h0, 32'h0, 0, 0, 0, 4'h0, 0, 0, 0, cc);
   endtask

   task automatic do_reset(input logic [3:0] cc);
      @(negedge clk);
      upd_en = 0; wr_en = 0; push = 0; pop = 0; err_clr = 0;
      rst_n = 1'b0;
      cond = cc;
      #1;
      chk("rst_flags", 32'(flags),     32'h0);
      chk("rst_cnt",   32'(depth_cnt), 32'h0);
      chk("rst_empty", 32'(empty),     32'h1);
      chk("rst_full",  32'(full),      32'h0);
      chk("rst_err",   32'(err),       32'h0);
      chk("rst_cond",  32'(cond_pass), 32'(m_cond(cc, 4'h0)));
      m_flags = 4'h0; m_err = 1'b0; m_stack.delete();
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      m_flags = 4'h0; m_err = 1'b0;
      do_reset(4'b1110);
      // ALU update with full mask, then EQ / HI checks.
      step(1, 4'hF, 32'h0, 1, 0, 0, 4'h0, 0, 0, 0, 4'b0000);
      idle(4'b0000);
      idle(4'b1000);
      // Update only V.
      step(1, 4'h1, 32'h8000_0000, 0, 1, 0, 4'h0, 0, 0, 0, 4'b1010);
      // push, write, pop restores.
      step(0, 4'h0, 32'h0, 0, 0, 0, 4'h0, 1, 0, 0, 4'b0110);
      step(0, 4'h0, 32'h0, 0, 0, 1, 4'h8, 0, 0, 0, 4'b0100);
      step(0, 4'h0, 32'h0, 0, 0, 0, 4'h0, 0, 1, 0, 4'b0111);
      // Five pushes overflow a 4-deep stack, then clear err.
      for (int i = 0; i < 5; i++)
         step(1, 4'hF, $urandom, 1'($urandom), 1'($urandom), 0, 4'h0, 1, 0, 0, 4'($urandom));
      step(0, 4'h0, 32'h0, 0, 0, 0, 4'h0, 0, 0, 1, 4'b1100);
      // Pop on empty with direct write.
      do_reset(4'b0000);
      step(0, 4'h0, 32'h0, 0, 0, 1, 4'h9, 0, 1, 0, 4'b1011);
      // Swap.
      do_reset(4'b1111);
      step(0, 4'h0, 32'h0, 0, 0, 1, 4'h3, 0, 0, 0, 4'b0010);
      step(0, 4'h0, 32'h0, 0, 0, 0, 4'h0, 1, 0, 0, 4'b0011);
      step(0, 4'h0, 32'h0, 0, 0, 1, 4'hC, 0, 0, 0, 4'b1101);
      step(0, 4'h0, 32'h0, 0, 0, 1, 4'h5, 1, 1, 0, 4'b1001);
      idle(4'b1100);
      do_reset(4'b1110);
      step(0, 4'h0, 32'h0, 0, 0, 0, 4'h0, 0, 1, 0, 4'b0001);
      // Randomized traffic.
      for (int i = 0; i < 600; i++) begin
         logic [31:0] res;
         case ($urandom_range(3))
            0: res = 32'h0;
            1: res = 32'h8000_0000;
            default: res = $urandom;
         endcase
         if ($urandom_range(79) == 0) do_reset(4'($urandom));
         else step(1'($urandom_range(1)), 4'($urandom), res, 1'($urandom), 1'($urandom),
                   ($urandom_range(4) == 0), 4'($urandom),
                   ($urandom_range(9) < 4), ($urandom_range(9) < 3),
                   ($urandom_range(9) == 0), 4'($urandom));
      end
      @(negedge clk);
      upd_en = 0; wr_en = 0; push = 0; pop = 0; err_clr = 0;
      for (int k = 0; k < 10 && exp_q.size() > 0; k++) @(negedge clk);
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_fail++;
         $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
